// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the CPU register file: sweep FSM states and bank geometry.
package cpu_regfile_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_DATA_WIDTH = 32;
   localparam int NUM_REGS       = 32;
   localparam int ZERO_REG       = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/decoder_onehot.sv
// Address to one-hot decoder with enable; the write-side counterpart of the 32:1 read mux.
module decoder_onehot #(
   parameter int ADDR_WIDTH = 5,
   localparam int OUT_WIDTH = 2**ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  en_i,
   output logic [OUT_WIDTH-1:0]  onehot_o
);

   // One-hot decode, all zero when disabled so an unknown address cannot leak through.
   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[addr_i] = 1'b1;
      end else begin
         onehot_o = '0;
      end
   end

endmodule

// File: rtl/regbank_write_port.sv
// Write side of the register file: one-hot decoded writes into 31 storage registers,
// register 0 hardwired to zero, and a one-register-per-cycle clear sweep that stalls writers.
module regbank_write_port #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   localparam int NUM_REGS  = 2**ADDR_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic                           clear_start,
   output logic                           clear_busy,
   output logic [NUM_REGS-1:0]            wr_onehot,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);
   import cpu_regfile_pkg::*;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   sweep_cnt_q;
   logic [NUM_REGS-1:0]     dec_s;
   logic [NUM_REGS-1:0]     wr_onehot_d;
   logic [NUM_REGS-1:0]     wr_onehot_q;
   logic [DATA_WIDTH-1:0]   regs_q [1:NUM_REGS-1];
   logic                    wr_accept_s;

   assign wr_ready    = (state_q == IDLE);
   assign clear_busy  = (state_q == CLEAR);
   assign wr_accept_s = wr_valid && wr_ready;
   assign wr_onehot   = wr_onehot_q;

   decoder_onehot #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dec (
      .addr_i   (wr_addr),
      .en_i     (wr_accept_s),
      .onehot_o (dec_s)
   );

   // Writes to register 0 complete the handshake but never show up as a commit.
   always_comb begin
      wr_onehot_d           = dec_s;
      wr_onehot_d[ZERO_REG] = 1'b0;
   end

   // Sweep FSM: the counter starts at 1 and the sweep ends once the last register is cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sweep_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clear_start) begin
                  state_q     <= CLEAR;
                  sweep_cnt_q <= ADDR_WIDTH'(1);
               end
            end
            CLEAR: begin
               if (sweep_cnt_q == ADDR_WIDTH'(NUM_REGS-1)) begin
                  state_q     <= IDLE;
                  sweep_cnt_q <= '0;
               end else begin
                  sweep_cnt_q <= sweep_cnt_q + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state_q     <= IDLE;
               sweep_cnt_q <= '0;
            end
         endcase
      end
   end

   // Storage: writes only land in IDLE, so they never collide with the sweep clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (clear_busy && (sweep_cnt_q == ADDR_WIDTH'(i))) begin
               regs_q[i] <= '0;
            end else if (dec_s[i]) begin
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   // Commit indicator, held for exactly one cycle per accepted nonzero write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_onehot_q <= '0;
      end else begin
         wr_onehot_q <= wr_onehot_d;
      end
   end

   assign regs_flat[DATA_WIDTH-1:0] = '0;
   for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

endmodule

// File: tb/tb_regbank_write_port.sv
// Randomised bench for regbank_write_port against a behavioural register-bank model,
// plus directed scenarios with hand-computed expectations.
module tb_regbank_write_port;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [AW-1:0]  wr_addr = '0;
   logic [DW-1:0]  wr_data = '0;
   logic           clear_start = 1'b0;
   logic           clear_busy;
   logic [NR-1:0]  wr_onehot;
   logic [NR*DW-1:0] regs_flat;

   regbank_write_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .wr_onehot   (wr_onehot),
      .regs_flat   (regs_flat)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Behavioural model: plain array, a busy flag and the next index the sweep will zero.
   logic [DW-1:0] m_reg [NR];
   bit            m_busy;
   int            m_next;
   logic [NR-1:0] m_onehot;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] dut_reg(input int i);
      return regs_flat[i*DW +: DW];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_busy   = 1'b0;
      m_next   = 0;
      m_onehot = '0;
   endtask

   task automatic model_step();
      bit acc;
      acc = wr_valid && !m_busy;
      m_onehot = '0;
      if (acc && wr_addr != 0) begin
         m_reg[wr_addr] = wr_data;
         m_onehot = NR'(1) << wr_addr;
      end
      if (m_busy) begin
         m_reg[m_next] = '0;
         if (m_next == NR-1) m_busy = 1'b0;
         else m_next = m_next + 1;
      end else if (clear_start) begin
         m_busy = 1'b1;
         m_next = 1;
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
         #1;
         for (int i = 0; i < NR; i++) begin
            check($sformatf("reg%0d", i), 64'(dut_reg(i)), 64'(m_reg[i]));
         end
         check("wr_ready", 64'(wr_ready), 64'(!m_busy));
         check("clear_busy", 64'(clear_busy), 64'(m_busy));
         check("wr_onehot", 64'(wr_onehot), 64'(m_onehot));
      end
   end

   task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Counts busy cycles seen at negedges until the sweep ends; optional re-pulse of clear_start.
   task automatic run_sweep(input int restart_at, output int n);
      bit done;
      n = 0;
      done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         clear_start = (c == restart_at);
         if (clear_busy) begin
            n++;
         end else begin
            done = 1'b1;
            break;
         end
      end
      clear_start = 1'b0;
      check("sweep_timeout", 64'(done), 64'(1));
   endtask

   int n;

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_ready", 64'(wr_ready), 64'(1));
      check("rst_busy", 64'(clear_busy), 64'(0));
      check("rst_onehot", 64'(wr_onehot), 64'(0));
      check("rst_regs", 64'(|regs_flat), 64'(0));

      // Basic write with one-cycle latency.
      write_reg(5'd5, 32'hDEADBEEF);
      check("w5_data", 64'(regs_flat[191:160]), 64'(32'hDEADBEEF));
      check("w5_onehot", 64'(wr_onehot), 64'(32'h0000_0020));
      for (int i = 0; i < NR; i++) begin
         if (i != 5) check($sformatf("w5_other%0d", i), 64'(dut_reg(i)), 64'(0));
      end
      @(negedge clk);
      check("w5_onehot_drop", 64'(wr_onehot), 64'(0));

      // Register 0 is never written.
      write_reg(5'd0, 32'hFFFFFFFF);
      check("r0_ready", 64'(wr_ready), 64'(1));
      check("r0_data", 64'(regs_flat[31:0]), 64'(0));
      check("r0_onehot", 64'(wr_onehot), 64'(0));

      // Random traffic with occasional clears.
      repeat (400) begin
         wr_valid    = 1'($urandom_range(0, 1));
         wr_addr     = AW'($urandom);
         wr_data     = $urandom;
         clear_start = ($urandom_range(0, 49) == 0);
         @(negedge clk);
      end
      wr_valid    = 1'b0;
      clear_start = 1'b0;
      if (clear_busy) run_sweep(-1, n);

      // Fill, then sweep while a write to reg 7 stalls; a second pulse mid-sweep is ignored.
      for (int i = 1; i < NR; i++) write_reg(AW'(i), DW'(i));
      check("fill_r31", 64'(dut_reg(31)), 64'(31));
      wr_valid    = 1'b1;
      wr_addr     = 5'd7;
      wr_data     = 32'h1234;
      clear_start = 1'b1;
      run_sweep(5, n);
      check("sweep_len", 64'(n), 64'(31));
      check("stall_r7_before", 64'(dut_reg(7)), 64'(0));
      @(negedge clk);
      wr_valid = 1'b0;
      check("stall_r7", 64'(dut_reg(7)), 64'(32'h1234));
      check("stall_r31", 64'(dut_reg(31)), 64'(0));

      // Clear and write on the same edge: the write lands first, then gets swept.
      wr_valid    = 1'b1;
      wr_addr     = 5'd3;
      wr_data     = 32'hAA;
      clear_start = 1'b1;
      @(negedge clk);
      wr_valid    = 1'b0;
      clear_start = 1'b0;
      check("simul_r3", 64'(dut_reg(3)), 64'(32'hAA));
      check("simul_busy", 64'(clear_busy), 64'(1));
      run_sweep(-1, n);
      check("simul_len", 64'(n), 64'(30));
      check("simul_r3_cleared", 64'(dut_reg(3)), 64'(0));

      // Asynchronous reset in the middle of a sweep.
      for (int i = 20; i < 26; i++) write_reg(AW'(i), DW'(32'hC0DE0000 + i));
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_busy", 64'(clear_busy), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(clear_busy), 64'(0));
      check("arst_ready", 64'(wr_ready), 64'(1));
      check("arst_onehot", 64'(wr_onehot), 64'(0));
      for (int i = 0; i < NR; i++) check($sformatf("arst_reg%0d", i), 64'(dut_reg(i)), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      repeat (100) begin
         wr_valid    = 1'($urandom_range(0, 1));
         wr_addr     = AW'($urandom);
         wr_data     = $urandom;
         clear_start = ($urandom_range(0, 29) == 0);
         @(negedge clk);
      end
      wr_valid    = 1'b0;
      clear_start = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
